// File: rtl/uart_tx_top_pkg.sv
// Shared UART definitions: FSM state encoding and line/parity constants used by TX and RX.
package uart_tx_top_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_tx_top_edge_bit_counter.sv
// Per-bit edge counter (0..P-1) and data-bit index (0..data_width-1) for the UART transmitter.
module tx_edge_bit_counter #(
  parameter int data_width     = 8,
  parameter int prescale_width = 6,
  parameter int idx_w          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_en,
  input  logic                      i_data_phase,
  input  logic [prescale_width-1:0] i_prescale,
  output logic                      o_bit_done_tick,
  output logic                      o_data_done_tick,
  output logic [idx_w-1:0]          o_bit_index
);

  logic [prescale_width-1:0] r_edge;
  logic [idx_w-1:0]          r_bit_index;
  logic                      w_bit_done;
  logic                      w_last_bit;

  // i_prescale is already clamped to >= 1 by the caller, so P-1 never underflows.
  assign w_bit_done = i_en && (r_edge == (i_prescale - prescale_width'(1)));
  assign w_last_bit = (r_bit_index == idx_w'(data_width - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_edge      <= '0;
      r_bit_index <= '0;
    end else if (i_en) begin
      if (w_bit_done) begin
        r_edge <= '0;
      end else begin
        r_edge <= r_edge + prescale_width'(1);
      end
      if (w_bit_done && i_data_phase) begin
        r_bit_index <= w_last_bit ? '0 : r_bit_index + idx_w'(1);
      end
    end
  end

  assign o_bit_done_tick  = w_bit_done;
  assign o_data_done_tick = w_bit_done && i_data_phase && w_last_bit;
  assign o_bit_index      = r_bit_index;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: latches a word on acceptance and shifts out start, data LSB first,
// optional parity and stop, each bit lasting the latched prescale count of tx_clk cycles.
module uart_tx_top
  import uart_tx_top_pkg::*;
#(
  parameter int data_width     = 8,
  parameter int prescale_width = 6
) (
  input  logic                      tx_clk,
  input  logic                      rst_n,
  input  logic [data_width-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [prescale_width-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy,
  output tx_state_e                 dbg_state
);

  localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;

  // Handshake: data_valid is a one-sided request with no ready. It is accepted only at an
  // edge where the FSM is IDLE (busy=0); any request seen while busy=1 is dropped silently.

  tx_state_e                 r_state;
  tx_state_e                 w_next_state;
  logic [data_width-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_bit;
  logic [prescale_width-1:0] r_prescale;
  logic                      r_tx_out;
  logic                      r_busy;

  logic                      w_accept;
  logic                      w_tx_next;
  logic                      w_busy_next;
  logic                      w_bit_done;
  logic                      w_data_done;
  logic [IDX_W-1:0]          w_bit_index;
  logic [IDX_W-1:0]          w_next_index;

  assign w_accept     = (r_state == S_IDLE) && data_valid;
  assign w_next_index = w_bit_index + IDX_W'(1);

  tx_edge_bit_counter #(
    .data_width     (data_width),
    .prescale_width (prescale_width),
    .idx_w          (IDX_W)
  ) u_counter (
    .clk              (tx_clk),
    .rst_n            (rst_n),
    .i_clear          (w_accept),
    .i_en             (r_state != S_IDLE),
    .i_data_phase     (r_state == S_DATA),
    .i_prescale       (r_prescale),
    .o_bit_done_tick  (w_bit_done),
    .o_data_done_tick (w_data_done),
    .o_bit_index      (w_bit_index)
  );

  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_prescale <= '0;
      r_tx_out   <= STOP_BIT;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_tx_out <= w_tx_next;
      r_busy   <= w_busy_next;
      if (w_accept) begin
        r_data     <= p_data;
        r_par_en   <= parity_enable;
        r_par_bit  <= (parity_type == PARITY_ODD) ? ~^p_data : ^p_data;
        r_prescale <= (prescale == '0) ? prescale_width'(1) : prescale;
      end
    end
  end

  // The next line level is decided one cycle ahead so tx_out is a plain flop output.
  always_comb begin
    w_next_state = r_state;
    w_tx_next    = r_tx_out;
    w_busy_next  = r_busy;
    case (r_state)
      S_IDLE: begin
        w_tx_next   = STOP_BIT;
        w_busy_next = 1'b0;
        if (data_valid) begin
          w_next_state = S_START;
          w_tx_next    = START_BIT;
          w_busy_next  = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_next_state = S_DATA;
          w_tx_next    = r_data[0];
        end
      end
      S_DATA: begin
        if (w_data_done) begin
          w_next_state = r_par_en ? S_PARITY : S_STOP;
          w_tx_next    = r_par_en ? r_par_bit : STOP_BIT;
        end else if (w_bit_done) begin
          w_tx_next = r_data[w_next_index];
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_next_state = S_STOP;
          w_tx_next    = STOP_BIT;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_next_state = S_IDLE;
          w_tx_next    = STOP_BIT;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_tx_next    = STOP_BIT;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign tx_out    = r_tx_out;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: directed frames feed an expected queue; a line monitor decodes
// every busy window from tx_out and compares it against the queue head.
module tb_uart_tx_top;
  import uart_tx_top_pkg::*;

  localparam int EXP_W = 30;
  localparam int MAX_S = 1024;

  logic       tx_clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;
  tx_state_e  dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_skip = 1'b0;

  uart_tx_top #(.data_width(8), .prescale_width(6)) dut (
    .tx_clk        (tx_clk),
    .rst_n         (rst_n),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .prescale      (prescale),
    .tx_out        (tx_out),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // entry: gap[29:28] len[27:16] pbit[15] pe[14] period[13:8] data[7:0]; gap 0 = unchecked
  function automatic logic [EXP_W-1:0] pack(input logic [7:0] d, input int period,
                                            input logic pe, input logic pbit,
                                            input int len, input int gap);
    return {gap[1:0], len[11:0], pbit, pe, period[5:0], d};
  endfunction

  task automatic wait_busy(input logic level, input string name);
    int k;
    k = 0;
    while (busy !== level && k < 5000) begin
      @(negedge tx_clk);
      k++;
    end
    if (busy !== level) check(name, busy, level);
  endtask

  // driver: one-cycle request, then scramble inputs to show they are ignored mid-frame
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                      input int period, input logic pbit, input int len, input bit do_push);
    wait_busy(1'b0, "wait_idle");
    p_data        = d;
    parity_enable = pe;
    parity_type   = pt;
    prescale      = ps;
    data_valid    = 1'b1;
    if (do_push) exp_q.push_back(pack(d, period, pe, pbit, len, 0));
    @(negedge tx_clk);
    data_valid    = 1'b0;
    p_data        = 8'($urandom_range(0, 255));
    prescale      = 6'($urandom_range(1, 63));
    parity_enable = ~pe;
    parity_type   = ~pt;
  endtask

  // monitor: capture tx_out for every cycle busy is high, then decode against queue head
  logic             line_s [MAX_S];
  logic [EXP_W-1:0] cur;
  int               n, gap_cnt, period, nbits, bad, len_exp;
  logic [7:0]       got_data;
  logic             exp_bit, skip, have_exp;

  initial begin
    gap_cnt = 1000;
    forever begin
      @(negedge tx_clk);
      if (busy !== 1'b1) begin
        gap_cnt++;
        continue;
      end
      skip     = mon_skip;
      have_exp = 1'b0;
      cur      = '0;
      if (!skip) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          have_exp = 1'b1;
          if (cur[29:28] != 2'd0) check("idle_gap", gap_cnt, int'(cur[29:28]));
        end
      end
      n = 0;
      while (busy === 1'b1 && n < MAX_S) begin
        line_s[n] = tx_out;
        n++;
        @(negedge tx_clk);
      end
      if (n >= MAX_S) check("busy_stuck", n, 0);
      gap_cnt = 1;
      if (have_exp) begin
        period  = int'(cur[13:8]);
        nbits   = 10 + int'(cur[14]);
        len_exp = int'(cur[27:16]);
        check("busy_len", n, len_exp);
        check("idle_high", tx_out, 1);
        bad = 0;
        for (int k = 0; k < nbits; k++) begin
          if (k == 0) exp_bit = START_BIT;
          else if (k <= 8) exp_bit = cur[k-1];
          else if (k == 9 && cur[14]) exp_bit = cur[15];
          else exp_bit = STOP_BIT;
          for (int c = k * period; c < (k + 1) * period; c++) begin
            if (c >= n || line_s[c] !== exp_bit) bad++;
          end
        end
        check("frame_shape", bad, 0);
        got_data = '0;
        for (int b = 0; b < 8; b++) begin
          if ((b + 1) * period + period / 2 < n) got_data[b] = line_s[(b + 1) * period + period / 2];
        end
        check("data", got_data, cur[7:0]);
        if (cur[14] && (9 * period + period / 2) < n) check("parity", line_s[9 * period + period / 2], cur[15]);
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; p_data = '0; data_valid = 1'b0;
    parity_enable = 1'b0; parity_type = 1'b0; prescale = 6'd8;
    repeat (3) @(negedge tx_clk);
    check("reset_tx_out", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge tx_clk);

    // directed vectors with hand-computed parity and busy lengths
    send(8'hA5, 1'b1, PARITY_EVEN, 6'd8,  8,  1'b0, 88,  1'b1);
    send(8'h00, 1'b1, PARITY_ODD,  6'd16, 16, 1'b1, 176, 1'b1);
    send(8'hFF, 1'b0, PARITY_EVEN, 6'd16, 16, 1'b0, 160, 1'b1);
    send(8'h01, 1'b0, PARITY_EVEN, 6'd0,  1,  1'b0, 10,  1'b1);
    send(8'h07, 1'b1, PARITY_EVEN, 6'd1,  1,  1'b1, 11,  1'b1);

    // request while busy is dropped
    send(8'hC3, 1'b0, PARITY_EVEN, 6'd8, 8, 1'b0, 80, 1'b1);
    repeat (20) @(negedge tx_clk);
    p_data = 8'h3C; data_valid = 1'b1;
    @(negedge tx_clk);
    data_valid = 1'b0;

    // reset at cycle 30 of a frame aborts it
    wait_busy(1'b0, "wait_idle");
    mon_skip = 1'b1;
    send(8'h5A, 1'b0, PARITY_EVEN, 6'd8, 8, 1'b0, 80, 1'b0);
    repeat (28) @(negedge tx_clk);
    rst_n = 1'b0;
    @(negedge tx_clk);
    check("abort_tx_out", tx_out, 1);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge tx_clk);
    mon_skip = 1'b0;
    send(8'h96, 1'b1, PARITY_ODD, 6'd4, 4, 1'b1, 44, 1'b1);

    // back-to-back with data_valid held high; inputs change only after each acceptance
    wait_busy(1'b0, "wait_idle");
    p_data = 8'h55; parity_enable = 1'b1; parity_type = PARITY_EVEN; prescale = 6'd8;
    data_valid = 1'b1;
    exp_q.push_back(pack(8'h55, 8, 1'b1, 1'b0, 88, 0));
    wait_busy(1'b1, "b2b_start");
    p_data = 8'hAA;
    exp_q.push_back(pack(8'hAA, 8, 1'b1, 1'b0, 88, 1));
    wait_busy(1'b0, "b2b_end");
    wait_busy(1'b1, "b2b_start");
    p_data = 8'h81;
    exp_q.push_back(pack(8'h81, 8, 1'b1, 1'b0, 88, 1));
    wait_busy(1'b0, "b2b_end");
    wait_busy(1'b1, "b2b_start");
    data_valid = 1'b0;

    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < 5000) begin
      @(negedge tx_clk);
      k++;
    end
    check("drain_queue", exp_q.size(), 0);
    repeat (4) @(negedge tx_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
